input_port_credit: RTL and testbench

- Receive-side counterpart of the leaf output-port logic.
- Accepts network packets addressed to one leaf input port and buffers their payloads in a BRAM FIFO of 2^NUM_BRAM_ADDR_BITS words.
- Delivers payloads to user logic over a valid/ack handshake.
- Returns freespace credit packets to the upstream sender: one initial credit after ap_start, then one credit per FREESPACE_UPDATE_SIZE words consumed.
- One instance per input port; a cluster wrapper replicates it.

---
 rtl/input_port_credit_if.sv | 28 ++
 rtl/input_port_credit.sv | 145 ++++++++++++++
 tb/tb_input_port_credit.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_port_credit_if.sv
// Network/user-facing bundle of one leaf input port: packet receive, user payload
// delivery and credit return toward the upstream sender.
interface input_port_credit_if #(
  parameter int PACKET_BITS  = 97,
  parameter int PAYLOAD_BITS = 64
);
  // Handshakes: a user payload moves on any cycle with vld_interface2user && ack_user2interface,
  // and dout is held while vld && !ack. A credit packet is popped on any cycle with
  // credit_rd_en && !credit_empty; credit_rd_en while credit_empty is ignored.
  // packet_in carries its own valid bit (MSB) and has no backpressure.
  logic [PACKET_BITS-1:0]  packet_in;
  logic [PAYLOAD_BITS-1:0] dout_leaf_interface2user;
  logic                    vld_interface2user;
  logic                    ack_user2interface;
  logic [PACKET_BITS-1:0]  credit_out;
  logic                    credit_empty;
  logic                    credit_rd_en;

  modport master (
    output packet_in, ack_user2interface, credit_rd_en,
    input  dout_leaf_interface2user, vld_interface2user, credit_out, credit_empty
  );

  modport slave (
    input  packet_in, ack_user2interface, credit_rd_en,
    output dout_leaf_interface2user, vld_interface2user, credit_out, credit_empty
  );
endinterface

// File: rtl/input_port_credit.sv
// Leaf input port: buffers incoming payloads in a BRAM FIFO, hands them to user logic
// and returns freespace credits upstream. Define INPUT_PORT_PKT_COUNT_EN to add pkt_count.
module input_port_credit #(
  parameter int PACKET_BITS           = 97,
  parameter int NUM_LEAF_BITS         = 6,
  parameter int NUM_PORT_BITS         = 4,
  parameter int PAYLOAD_BITS          = 64,
  parameter int NUM_BRAM_ADDR_BITS    = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_LEAF_BITS-1:0] src_leaf,
  input  logic [NUM_PORT_BITS-1:0] src_port,
  input_port_credit_if.slave       bus,
  output logic                     overflow,
  input  logic                     ap_start,
  output logic [1:0]               fsm_state
`ifdef INPUT_PORT_PKT_COUNT_EN
  ,
  output logic [15:0]              pkt_count
`endif
);
  localparam int DEPTH = 1 << NUM_BRAM_ADDR_BITS;
  localparam int CW    = NUM_BRAM_ADDR_BITS + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_INIT = 2'd1, S_WAIT = 2'd2, S_RUN = 2'd3} state_t;

  logic [PAYLOAD_BITS-1:0]       mem [DEPTH];
  logic [NUM_BRAM_ADDR_BITS-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]                 count, avail, consumed;
  logic [PAYLOAD_BITS-1:0]       dout_q;
  logic                          vld_q;
  logic [PACKET_BITS-1:0]        credit_q;
  logic                          credit_empty_q;
  logic                          wr_en, rd_en, xfer, pkt_valid, pkt_unused;
  state_t                        state, next_state;
  logic                          load_credit, pop_credit;
  logic [PAYLOAD_BITS-1:0]       credit_val;

  assign pkt_valid  = bus.packet_in[PACKET_BITS-1];
  assign pkt_unused = ^bus.packet_in[PACKET_BITS-2:PAYLOAD_BITS];

  // count includes the word sitting in the output register, so total capacity is DEPTH
  assign avail = count - {{(CW-1){1'b0}}, vld_q};
  assign wr_en = pkt_valid && (count != CW'(DEPTH));
  assign xfer  = vld_q && bus.ack_user2interface;
  assign rd_en = (avail != '0) && (!vld_q || bus.ack_user2interface);

  function automatic logic [PACKET_BITS-1:0] make_credit(input logic [PAYLOAD_BITS-1:0] value,
                                                         input logic [NUM_LEAF_BITS-1:0] leaf,
                                                         input logic [NUM_PORT_BITS-1:0] port);
    logic [PACKET_BITS-1:0] pkt;
    pkt = '0;
    pkt[PACKET_BITS-1] = 1'b1;
    pkt[PACKET_BITS-2 -: NUM_LEAF_BITS] = leaf;
    pkt[PACKET_BITS-2-NUM_LEAF_BITS -: NUM_PORT_BITS] = port;
    pkt[PAYLOAD_BITS-1:0] = value;
    return pkt;
  endfunction

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.packet_in[PAYLOAD_BITS-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      dout_q   <= '0;
      vld_q    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pkt_valid && !wr_en) overflow <= 1'b1;
      count <= count + CW'(wr_en) - CW'(xfer);
      if (rd_en) begin
        dout_q <= mem[rd_ptr];
        vld_q  <= 1'b1;
        rd_ptr <= rd_ptr + 1'b1;
      end else if (xfer) begin
        vld_q  <= 1'b0;
      end
    end
  end

  always_comb begin
    next_state  = state;
    load_credit = 1'b0;
    pop_credit  = 1'b0;
    credit_val  = '0;
    case (state)
      S_IDLE: if (ap_start) next_state = S_INIT;
      S_INIT: begin
        load_credit = 1'b1;
        credit_val  = PAYLOAD_BITS'(DEPTH);
        next_state  = S_WAIT;
      end
      S_WAIT: if (bus.credit_rd_en && !credit_empty_q) begin
        pop_credit = 1'b1;
        next_state = S_RUN;
      end
      S_RUN: if (consumed >= CW'(FREESPACE_UPDATE_SIZE)) begin
        load_credit = 1'b1;
        credit_val  = PAYLOAD_BITS'(FREESPACE_UPDATE_SIZE);
        next_state  = S_WAIT;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      credit_q       <= '0;
      credit_empty_q <= 1'b1;
      consumed       <= '0;
    end else begin
      state <= next_state;
      if (load_credit) begin
        credit_q       <= make_credit(credit_val, src_leaf, src_port);
        credit_empty_q <= 1'b0;
      end else if (pop_credit) begin
        credit_empty_q <= 1'b1;
      end
      // a credit issued from RUN retires FREESPACE_UPDATE_SIZE alongside any same-cycle transfer
      consumed <= consumed + CW'(xfer)
                  - ((load_credit && state == S_RUN) ? CW'(FREESPACE_UPDATE_SIZE) : '0);
    end
  end

`ifdef INPUT_PORT_PKT_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              pkt_count <= '0;
    else if (wr_en && pkt_count != 16'hFFFF) pkt_count <= pkt_count + 16'd1;
  end
`endif

  assign bus.dout_leaf_interface2user = dout_q;
  assign bus.vld_interface2user       = vld_q;
  assign bus.credit_out               = credit_q;
  assign bus.credit_empty             = credit_empty_q;
  assign fsm_state                    = state;
endmodule

// File: tb/tb_input_port_credit.sv
// Directed bench for input_port_credit: receive/deliver, stall, overflow, credit return, reset.
module tb_input_port_credit;
  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  src_leaf;
  logic [3:0]  src_port;
  logic        overflow;
  logic        ap_start;
  logic [1:0]  fsm_state;
`ifdef INPUT_PORT_PKT_COUNT_EN
  logic [15:0] pkt_count;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_port_credit_if #(.PACKET_BITS(97), .PAYLOAD_BITS(64)) bus ();

  input_port_credit dut (
    .clk       (clk),
    .reset     (reset),
    .src_leaf  (src_leaf),
    .src_port  (src_port),
    .bus       (bus),
    .overflow  (overflow),
    .ap_start  (ap_start),
    .fsm_state (fsm_state)
`ifdef INPUT_PORT_PKT_COUNT_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [96:0] mk_pkt(input logic [63:0] payload);
    logic [96:0] p;
    p = '0;
    p[96] = 1'b1;
    p[95:90] = 6'h2A;
    p[89:86] = 4'h9;
    p[63:0] = payload;
    return p;
  endfunction

  task automatic send_words(input int n);
    bus.ack_user2interface = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.packet_in = mk_pkt(64'(i) + 64'h5000);
      tick();
    end
    bus.packet_in = '0;
    repeat (5) tick();
  endtask

  task automatic pop_credit();
    bus.credit_rd_en = 1'b1;
    tick();
    bus.credit_rd_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ap_start = 1'b0;
    src_leaf = '0;
    src_port = '0;
    bus.packet_in = '0;
    bus.ack_user2interface = 1'b0;
    bus.credit_rd_en = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.vld_interface2user !== 1'b0 || bus.dout_leaf_interface2user !== 64'h0) begin
      errors++;
      $display("FAIL reset_user: vld=%b dout=%h, required vld=0 dout=0",
               bus.vld_interface2user, bus.dout_leaf_interface2user);
    end
    checks++;
    if (bus.credit_empty !== 1'b1 || bus.credit_out !== 97'h0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_credit: empty=%b credit=%h ovf=%b, required 1/0/0",
               bus.credit_empty, bus.credit_out, overflow);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (fsm_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_idle: state=%0d, required 0", fsm_state);
    end
  endtask

  task automatic test_init_credit();
    logic [96:0] exp;
    exp = '0;
    exp[96] = 1'b1;
    exp[95:90] = 6'd5;
    exp[89:86] = 4'd3;
    exp[63:0] = 64'd128;
    src_leaf = 6'd5;
    src_port = 4'd3;
    ap_start = 1'b1;
    tick();
    checks++;
    if (fsm_state !== 2'd1) begin
      errors++;
      $display("FAIL init_state: state=%0d, required 1", fsm_state);
    end
    tick();
    checks++;
    if (bus.credit_empty !== 1'b0 || bus.credit_out !== exp) begin
      errors++;
      $display("FAIL init_credit: empty=%b credit=%h, required empty=0 credit=%h",
               bus.credit_empty, bus.credit_out, exp);
    end
    ap_start = 1'b0;
    pop_credit();
    checks++;
    if (bus.credit_empty !== 1'b1 || fsm_state !== 2'd3) begin
      errors++;
      $display("FAIL init_pop: empty=%b state=%0d, required empty=1 state=3",
               bus.credit_empty, fsm_state);
    end
    tick();
    checks++;
    if (fsm_state !== 2'd3) begin
      errors++;
      $display("FAIL ap_start_drop: state=%0d, required 3", fsm_state);
    end
  endtask

  task automatic test_basic();
    logic [63:0] exp_q[$];
    exp_q = '{64'hA, 64'hB, 64'hC};
    bus.ack_user2interface = 1'b1;
    bus.packet_in = mk_pkt(64'hA);
    tick();
    checks++;
    if (bus.vld_interface2user !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency: vld=%b one cycle after write, required 0", bus.vld_interface2user);
    end
    bus.packet_in = mk_pkt(64'hB);
    tick();
    bus.packet_in = mk_pkt(64'hC);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.vld_interface2user !== 1'b1 || bus.dout_leaf_interface2user !== exp_q[i]) begin
        errors++;
        $display("FAIL basic_word%0d: vld=%b dout=%h, required vld=1 dout=%h",
                 i, bus.vld_interface2user, bus.dout_leaf_interface2user, exp_q[i]);
      end
      tick();
      bus.packet_in = '0;
    end
    checks++;
    if (bus.vld_interface2user !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: vld=%b, required 0", bus.vld_interface2user);
    end
  endtask

  task automatic test_stall();
    bus.ack_user2interface = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.packet_in = mk_pkt(64'h10 + 64'(i));
      tick();
    end
    bus.packet_in = '0;
    repeat (3) begin
      tick();
      checks++;
      if (bus.vld_interface2user !== 1'b1 || bus.dout_leaf_interface2user !== 64'h10) begin
        errors++;
        $display("FAIL stall_hold: vld=%b dout=%h, required vld=1 dout=10",
                 bus.vld_interface2user, bus.dout_leaf_interface2user);
      end
    end
    bus.ack_user2interface = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.vld_interface2user !== 1'b1 || bus.dout_leaf_interface2user !== 64'h10 + 64'(i)) begin
        errors++;
        $display("FAIL stall_release%0d: vld=%b dout=%h, required vld=1 dout=%h",
                 i, bus.vld_interface2user, bus.dout_leaf_interface2user, 64'h10 + 64'(i));
      end
      tick();
    end
    checks++;
    if (bus.vld_interface2user !== 1'b0) begin
      errors++;
      $display("FAIL stall_drain: vld=%b, required 0", bus.vld_interface2user);
    end
  endtask

  task automatic test_overflow();
    int bad;
    bad = 0;
    bus.ack_user2interface = 1'b0;
    for (int i = 0; i < 128; i++) begin
      bus.packet_in = mk_pkt(64'h100 + 64'(i));
      tick();
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full: overflow=%b with 128 words, required 0", overflow);
    end
    bus.packet_in = mk_pkt(64'hBAD);
    tick();
    bus.packet_in = '0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: overflow=%b, required 1", overflow);
    end
`ifdef INPUT_PORT_PKT_COUNT_EN
    checks++;
    if (pkt_count !== 16'd135) begin
      errors++;
      $display("FAIL pkt_count: got %0d, required 135", pkt_count);
    end
`endif
    bus.ack_user2interface = 1'b1;
    for (int i = 0; i < 128; i++) begin
      checks++;
      if (bus.vld_interface2user !== 1'b1 || bus.dout_leaf_interface2user !== 64'h100 + 64'(i)) begin
        errors++;
        if (bad < 4)
          $display("FAIL ovf_word%0d: vld=%b dout=%h, required vld=1 dout=%h",
                   i, bus.vld_interface2user, bus.dout_leaf_interface2user, 64'h100 + 64'(i));
        bad++;
      end
      tick();
    end
    checks++;
    if (bus.vld_interface2user !== 1'b0) begin
      errors++;
      $display("FAIL ovf_no_extra: vld=%b dout=%h, required vld=0",
               bus.vld_interface2user, bus.dout_leaf_interface2user);
    end
    tick();
    tick();
    checks++;
    if (bus.credit_empty !== 1'b0 || bus.credit_out[63:0] !== 64'd64) begin
      errors++;
      $display("FAIL ovf_credit: empty=%b payload=%0d, required empty=0 payload=64",
               bus.credit_empty, bus.credit_out[63:0]);
    end
  endtask

  task automatic test_reset_mid();
    bus.ack_user2interface = 1'b0;
    bus.packet_in = mk_pkt(64'h77);
    tick();
    bus.packet_in = mk_pkt(64'h78);
    tick();
    bus.packet_in = '0;
    tick();
    checks++;
    if (bus.vld_interface2user !== 1'b1 || bus.credit_empty !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: vld=%b empty=%b ovf=%b, required 1/0/1",
               bus.vld_interface2user, bus.credit_empty, overflow);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.vld_interface2user !== 1'b0 || bus.credit_empty !== 1'b1 || overflow !== 1'b0 ||
        bus.credit_out !== 97'h0) begin
      errors++;
      $display("FAIL mid_reset: vld=%b empty=%b ovf=%b credit=%h, required 0/1/0/0",
               bus.vld_interface2user, bus.credit_empty, overflow, bus.credit_out);
    end
`ifdef INPUT_PORT_PKT_COUNT_EN
    checks++;
    if (pkt_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_pkt_count: got %0d, required 0", pkt_count);
    end
`endif
    tick();
    reset = 1'b0;
  endtask

  task automatic test_credit_return();
    ap_start = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.credit_empty !== 1'b0 || bus.credit_out[63:0] !== 64'd128) begin
      errors++;
      $display("FAIL cr_init: empty=%b payload=%0d, required 0/128", bus.credit_empty, bus.credit_out[63:0]);
    end
    pop_credit();
    send_words(63);
    checks++;
    if (bus.credit_empty !== 1'b1) begin
      errors++;
      $display("FAIL cr_63: empty=%b after 63 words, required 1", bus.credit_empty);
    end
    send_words(1);
    checks++;
    if (bus.credit_empty !== 1'b0 || bus.credit_out[63:0] !== 64'd64) begin
      errors++;
      $display("FAIL cr_64: empty=%b payload=%0d, required 0/64", bus.credit_empty, bus.credit_out[63:0]);
    end
    send_words(70);
    checks++;
    if (bus.credit_empty !== 1'b0 || fsm_state !== 2'd2) begin
      errors++;
      $display("FAIL cr_pending: empty=%b state=%0d, required 0/2", bus.credit_empty, fsm_state);
    end
    pop_credit();
    checks++;
    if (bus.credit_empty !== 1'b1 || fsm_state !== 2'd3) begin
      errors++;
      $display("FAIL cr_pop: empty=%b state=%0d, required 1/3", bus.credit_empty, fsm_state);
    end
    tick();
    checks++;
    if (bus.credit_empty !== 1'b0 || bus.credit_out[63:0] !== 64'd64) begin
      errors++;
      $display("FAIL cr_immediate: empty=%b payload=%0d, required 0/64", bus.credit_empty, bus.credit_out[63:0]);
    end
    pop_credit();
    pop_credit();
    checks++;
    if (bus.credit_empty !== 1'b1 || fsm_state !== 2'd3) begin
      errors++;
      $display("FAIL cr_spurious_pop: empty=%b state=%0d, required 1/3", bus.credit_empty, fsm_state);
    end
    send_words(57);
    checks++;
    if (bus.credit_empty !== 1'b1) begin
      errors++;
      $display("FAIL cr_residual63: empty=%b, required 1", bus.credit_empty);
    end
    send_words(1);
    checks++;
    if (bus.credit_empty !== 1'b0 || bus.credit_out[63:0] !== 64'd64) begin
      errors++;
      $display("FAIL cr_residual64: empty=%b payload=%0d, required 0/64", bus.credit_empty, bus.credit_out[63:0]);
    end
  endtask

  initial begin
    test_reset();
    test_init_credit();
    test_basic();
    test_stall();
    test_overflow();
    test_reset_mid();
    test_credit_return();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
